// File: rtl/memory_map_pkg.sv
// memory_map_pkg: I/O window addresses, status bit layout and address decode shared by the memory system.
package memory_map_pkg;
  localparam logic [15:0] CONSOLE_DATA_ADDR = 16'hFFF0;
  localparam logic [15:0] CONSOLE_STATUS_ADDR = 16'hFFF1;
  localparam logic [15:0] CYCLE_ADDR = 16'hFFF2;
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF = 2;
  localparam int STAT_COUNT_LSB = 4;
  typedef enum logic [2:0] {REG_RAM, REG_CDATA, REG_CSTAT, REG_CYCLE, REG_NONE} region_e;
  function automatic region_e decode(input logic [15:0] addr, input logic [15:0] depth);
    return addr < depth ? REG_RAM :
           addr == CONSOLE_DATA_ADDR ? REG_CDATA :
           addr == CONSOLE_STATUS_ADDR ? REG_CSTAT :
           addr == CYCLE_ADDR ? REG_CYCLE : REG_NONE;
  endfunction
endpackage

// File: rtl/console_fifo.sv
// console_fifo: power-of-two circular FIFO; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module console_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [WIDTH-1:0] push_data,
  input  logic pop,
  output logic [WIDTH-1:0] head,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == FULL_COUNT;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/memory_system.sv
// memory_system: word-addressed RAM with preload port plus an I/O window holding a console FIFO, status and a cycle counter.
module memory_system
  import memory_map_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [15:0] memory_addr,
  input  logic [15:0] memory_out,
  input  logic memory_write,
  output logic [15:0] memory_in,
  input  logic load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] out_data,
  output logic out_valid,
  input  logic out_ready,
  output logic overflow
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);
  if (DEPTH < 1 || DEPTH > 'hFFF0) begin : g_bad_depth
    $error("DEPTH must be 1..0xFFF0");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of two from 2 to 16");
  end
  logic [15:0] ram [DEPTH];
  logic [15:0] cycle, status;
  logic [CW-1:0] count;
  logic full, empty, push, pop, dropped, status_write;
  region_e cpu_region;
  assign cpu_region = decode(memory_addr, DEPTH16);
  assign push = memory_write && cpu_region == REG_CDATA;
  assign status_write = memory_write && cpu_region == REG_CSTAT;
  assign pop = out_valid && out_ready;
  assign dropped = push && full && !pop;
  assign out_valid = !empty;
  console_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(memory_out),
    .pop(pop),
    .head(out_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
  // RAM is deliberately outside reset so contents survive it; preload beats a CPU store.
  always_ff @(posedge clk) begin
    if (load_en && load_addr < DEPTH16) ram[load_addr[AW-1:0]] <= load_data;
    else if (memory_write && cpu_region == REG_RAM) ram[memory_addr[AW-1:0]] <= memory_out;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle <= '0;
      overflow <= 1'b0;
    end else begin
      cycle <= cycle + 16'd1;
      overflow <= dropped || (overflow && !status_write);
    end
  end
  always_comb begin
    status = '0;
    status[STAT_EMPTY] = empty;
    status[STAT_FULL] = full;
    status[STAT_OVF] = overflow;
    status[STAT_COUNT_LSB +: 5] = 5'(count);
    memory_in = cpu_region == REG_RAM ? ram[memory_addr[AW-1:0]] :
                cpu_region == REG_CSTAT ? status :
                cpu_region == REG_CYCLE ? cycle : '0;
  end
endmodule

// File: tb/tb_memory_system.sv
// tb_memory_system: directed checks of RAM, console FIFO, overflow, cycle counter and reset behaviour.
module tb_memory_system;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] memory_addr, memory_out, memory_in;
  logic memory_write;
  logic load_en;
  logic [15:0] load_addr, load_data;
  logic [15:0] out_data;
  logic out_valid, out_ready, overflow;
  int checks = 0;
  int errors = 0;

  memory_system #(.DEPTH(256), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .memory_addr(memory_addr),
    .memory_out(memory_out),
    .memory_write(memory_write),
    .memory_in(memory_in),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
    memory_addr = a;
    #1;
    check(tag, memory_in, exp);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    memory_addr = 16'hFFF0;
    memory_out = d;
    memory_write = 1'b1;
    tick();
    memory_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    memory_addr = '0;
    memory_out = '0;
    memory_write = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_data", out_data, 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    reset = 1'b0;
    rd(16'hFFF1, "rst_status", 16'h0001);
    rd(16'hFFF2, "cyc_0", 16'd0);
    tick();
    rd(16'hFFF2, "cyc_1", 16'd1);
    repeat (9) tick();
    rd(16'hFFF2, "cyc_10", 16'd10);
    repeat (65526) tick();
    rd(16'hFFF2, "cyc_wrap", 16'd0);

    load(16'd0, 16'h5A5A);
    load(16'd5, 16'h1234);
    load(16'd6, 16'h0606);
    rd(16'd5, "ram_pre", 16'h1234);
    memory_out = 16'hBEEF;
    memory_write = 1'b1;
    #1;
    check("ram_raw_old", memory_in, 16'h1234);
    tick();
    memory_write = 1'b0;
    rd(16'd5, "ram_raw_new", 16'hBEEF);
    rd(16'h0100, "ram_oob", 16'h0000);
    rd(16'h1234, "unmapped", 16'h0000);
    rd(16'hFFF0, "cdata_rd", 16'h0000);
    memory_addr = 16'd6;
    memory_out = 16'h6666;
    memory_write = 1'b1;
    load_en = 1'b1;
    load_addr = 16'd7;
    load_data = 16'h7777;
    tick();
    memory_write = 1'b0;
    load_en = 1'b0;
    rd(16'd6, "load_prio_cpu", 16'h0606);
    rd(16'd7, "load_prio_load", 16'h7777);
    load(16'h0100, 16'hFFFF);
    rd(16'd0, "load_oob", 16'h5A5A);
    memory_addr = 16'hFFF2;
    memory_out = 16'h9999;
    memory_write = 1'b1;
    tick();
    memory_write = 1'b0;
    rd(16'd0, "cyc_wr_ram", 16'h5A5A);

    memory_addr = 16'hFFF0;
    memory_out = 16'h00A1;
    memory_write = 1'b1;
    #1;
    check("no_bypass", 16'(out_valid), 16'h0);
    tick();
    memory_write = 1'b0;
    check("push_valid", 16'(out_valid), 16'h1);
    check("push_head", out_data, 16'h00A1);
    push(16'h00A2);
    push(16'h00A3);
    rd(16'hFFF1, "stat_cnt3", 16'h0030);
    out_ready = 1'b1;
    #1;
    check("drain_a1", out_data, 16'h00A1);
    tick();
    check("drain_a2", out_data, 16'h00A2);
    tick();
    check("drain_a3", out_data, 16'h00A3);
    tick();
    check("drain_valid", 16'(out_valid), 16'h0);
    out_ready = 1'b0;
    rd(16'hFFF1, "drain_empty", 16'h0001);

    push(16'h0011);
    push(16'h0012);
    push(16'h0013);
    push(16'h0014);
    rd(16'hFFF1, "stat_full", 16'h0042);
    check("full_no_ovf", 16'(overflow), 16'h0);
    push(16'h0015);
    check("ovf_set", 16'(overflow), 16'h1);
    rd(16'hFFF1, "stat_ovf", 16'h0046);
    check("ovf_head", out_data, 16'h0011);
    memory_addr = 16'hFFF1;
    memory_out = 16'h0000;
    memory_write = 1'b1;
    tick();
    memory_write = 1'b0;
    check("ovf_clr", 16'(overflow), 16'h0);
    rd(16'hFFF1, "stat_clr", 16'h0042);

    memory_addr = 16'hFFF0;
    memory_out = 16'h00CC;
    memory_write = 1'b1;
    out_ready = 1'b1;
    tick();
    memory_write = 1'b0;
    rd(16'hFFF1, "pp_count", 16'h0042);
    check("pp_ovf", 16'(overflow), 16'h0);
    check("pp_12", out_data, 16'h0012);
    tick();
    check("pp_13", out_data, 16'h0013);
    tick();
    check("pp_14", out_data, 16'h0014);
    tick();
    check("pp_cc", out_data, 16'h00CC);
    tick();
    check("pp_empty", 16'(out_valid), 16'h0);
    out_ready = 1'b0;

    push(16'h0021);
    push(16'h0022);
    check("pend_valid", 16'(out_valid), 16'h1);
    check("pend_head", out_data, 16'h0021);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 16'(out_valid), 16'h0);
    check("mid_rst_data", out_data, 16'h0000);
    rd(16'hFFF1, "mid_rst_status", 16'h0001);
    rd(16'hFFF2, "mid_rst_cyc", 16'd0);
    rd(16'd5, "keep_5", 16'hBEEF);
    rd(16'd0, "keep_0", 16'h5A5A);
    rd(16'd7, "keep_7", 16'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_system.md
# memory_system

Word-addressed memory responder that serves the CPU's memory interface: combinational reads, writes on the rising clock edge, a bench/boot preload port, and a small memory-mapped I/O window. The I/O window holds a console output FIFO, which the CPU fills by storing to a fixed address and an external consumer drains over a valid/ready handshake. A free-running cycle counter is also mapped there. The block sits directly opposite the CPU's memory_addr/memory_out/memory_write/memory_in ports and replaces the behavioural array used in CPU-level benches.

## Interface
- DEPTH, 256: RAM words, mapped at addresses 0..DEPTH-1. Must be at most 0xFFF0.
- FIFO_DEPTH, 4: console FIFO entries. Must be a power of two, from 2 to 16.
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- memory_addr  input  16  word address from CPU
- memory_out  input  16  write data from CPU
- memory_write  input  1  CPU write strobe, sampled at posedge clk
- memory_in  output  16  read data to CPU, combinational from memory_addr and current state
- load_en  input  1  preload write strobe; has priority over a CPU write to RAM in the same cycle
- load_addr  input  16  preload word address; ignored if it is DEPTH or above
- load_data  input  16  preload data
- out_data  output  16  FIFO head word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts the head when out_valid && out_ready at posedge
- overflow  output  1  sticky flag: a console write was dropped

## Operation
- Memory map:
  - 0..DEPTH-1: RAM.
  - 0xFFF0 CONSOLE_DATA: write pushes memory_out into the FIFO; read returns 0.
  - 0xFFF1 CONSOLE_STATUS: read returns bit0 empty, bit1 full, bit2 overflow, bits[8:4] count, all other bits 0. Any write clears overflow.
  - 0xFFF2 CYCLE: read returns the counter; writes are ignored.
  - Any other address: reads return 0 and writes are ignored.
- RAM:
  - RAM is not cleared by reset; its contents persist through reset.
  - A CPU write to RAM commits at posedge when memory_write is high.
  - A same-address read in that cycle still returns the old word. The new word is visible from the next cycle.
  - If load_en targets a RAM word in the same cycle as a CPU write to RAM, load_data wins whether or not the addresses match, and the CPU write is discarded.
- Console FIFO:
  - A push is a posedge with memory_write high and memory_addr equal to 0xFFF0.
  - A pop is a posedge with out_valid and out_ready both high.
  - Push while not full: the word is accepted.
  - Push while full with no pop that cycle: the word is dropped and overflow is set.
  - Push while full with a pop that cycle: the word is accepted and count is unchanged.
  - Push and pop together when non-empty: count is unchanged and FIFO order is preserved.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
  - out_data is the head entry. It is held stable while out_valid is high and no pop occurs.
- overflow:
  - Clear and set in the same cycle (status write plus a dropped push): set wins.
- Cycle counter:
  - 16 bits, increments every cycle, wraps 0xFFFF to 0.

## Timing
- Reset values:
  - FIFO: count 0, pointers 0, out_valid 0, out_data 0.
  - overflow 0, cycle counter 0.
  - memory_in follows the address decode; a RAM address returns the preserved RAM word.
- The first cycle after reset reads CYCLE = 0, and the count is 1 per cycle after that.
- Push latency: out_valid rises the cycle after a push into an empty FIFO. There is no bypass path.
- Status latency: a STATUS read reflects the state registered at the last edge, so a push or pop is visible one cycle later.
- Reset asserted mid-drain empties the FIFO at that edge. Words not yet popped are lost and out_valid drops.
- memory_in has zero-cycle latency and contains no registers.

## Structure
- Package memory_map_pkg holds:
  - address constants CONSOLE_DATA_ADDR, CONSOLE_STATUS_ADDR, CYCLE_ADDR
  - status bit positions STAT_EMPTY, STAT_FULL, STAT_OVF, STAT_COUNT_LSB
- Sub-module console_fifo:
  - parameters DEPTH and width
  - ports push/push_data, pop, head, count, full, empty
  - synchronous reset
- Top level holds the RAM array, the address decode, the overflow flag and the cycle counter.

## Test plan
- RAM read-after-write:
  - Preload word 5 = 0x1234. CPU writes 0xBEEF to address 5.
  - Same cycle, memory_in reads 0x1234. Next cycle it reads 0xBEEF.
  - Address 0x0100 with DEPTH = 256 reads 0.
- Console order:
  - CPU pushes 0xA1, 0xA2, 0xA3 with out_ready = 0. STATUS then reads count 3.
  - Raise out_ready. The consumer receives 0xA1, 0xA2, 0xA3 on consecutive cycles.
  - out_valid falls after the third pop; empty = 1.
- Overflow:
  - Push 5 words with FIFO_DEPTH = 4 and out_ready = 0. The fifth word is dropped; overflow = 1 and STATUS bit2 = 1.
  - Write to 0xFFF1. overflow = 0 the next cycle.
- Full with simultaneous push and pop:
  - FIFO full, out_ready = 1 and a push of 0xCC in the same cycle.
  - Count stays 4, overflow stays 0, and 0xCC drains last.
- Cycle counter and reset:
  - Read 0xFFF2 on reset-release+1, +10 and +65536 cycles; expect 1, 10 and 0 respectively.
  - Reset while 2 FIFO entries are pending: out_valid = 0 after the edge, and RAM contents are unchanged.
